// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the writeback arbiter slice.
// Queue entry layout and the hardwired zero register live here.
package rf_arb_pkg;

  localparam int DW_DEF    = 64;
  localparam int AW_DEF    = 5;
  localparam int DEPTH_DEF = 2;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd31;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request, hazard query and register-file write port bundle.
// master drives requests; slave is the arbiter.
interface regfile_wb_arbiter_if
  import rf_arb_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic [1:0]    req_valid;
  logic [AW-1:0] req_addr0;
  logic [AW-1:0] req_addr1;
  logic [DW-1:0] req_data0;
  logic [DW-1:0] req_data1;
  logic [1:0]    req_ready;
  logic          wb_hold;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic          hazard1;
  logic          hazard2;
  logic          RegWrite;
  logic [AW-1:0] WriteRegister;
  logic [DW-1:0] WriteData;

  modport master (
    output req_valid, req_addr0, req_addr1,
    output req_data0, req_data1, wb_hold,
    output rd_addr1, rd_addr2,
    input  req_ready, hazard1, hazard2,
    input  RegWrite, WriteRegister, WriteData
  );

  modport slave (
    input  req_valid, req_addr0, req_addr1,
    input  req_data0, req_data1, wb_hold,
    input  rd_addr1, rd_addr2,
    output req_ready, hazard1, hazard2,
    output RegWrite, WriteRegister, WriteData
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant with a 1-bit priority pointer.
// A lone requester always wins; contention goes to the pointer.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  // after an accept from requester i, favour requester 1-i
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= gnt[0];
    end
  end

  // grant decode
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      req == 2'b01:          gnt = 2'b01;
      req == 2'b10:          gnt = 2'b10;
      req == 2'b11 && !ptr:  gnt = 2'b01;
      req == 2'b11 &&  ptr:  gnt = 2'b10;
      default:               gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load writebacks into one in-order write queue
// feeding a registered register-file port, with hazard lookup.
module regfile_wb_arbiter
  import rf_arb_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic             clk,
  input logic             rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t     q [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] count;
  logic [1:0]    gnt;
  logic [1:0]    ready;
  logic [1:0]    acc;
  logic          pop;
  logic          push;
  logic          space;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          reg_write;
  logic [AW-1:0] wr_reg;
  logic [DW-1:0] wr_data;
  logic          hz1;
  logic          hz2;
  logic [PW-1:0] idx;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .advance (|acc),
    .gnt     (gnt)
  );

  // accept/push/pop decisions; a pop frees a slot the same cycle
  always_comb begin
    pop     = (count != '0) && !bus.wb_hold;
    space   = (count < CW'(DEPTH)) || pop;
    ready   = (rst && space) ? gnt : 2'b00;
    acc     = bus.req_valid & ready;
    in_addr = acc[1] ? bus.req_addr1 : bus.req_addr0;
    in_data = acc[1] ? bus.req_data1 : bus.req_data0;
    push    = (|acc) && (in_addr != AW'(REG_ZERO));
  end

  // write queue pointers, count and storage
  always_ff @(posedge clk) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q[wp] <= '{addr: in_addr, data: in_data};
        wp    <= nxt(wp);
      end
      if (pop) begin
        rp <= nxt(rp);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // registered register-file write port
  always_ff @(posedge clk) begin
    if (!rst) begin
      reg_write <= 1'b0;
      wr_reg    <= '0;
      wr_data   <= '0;
    end else if (pop) begin
      reg_write <= 1'b1;
      wr_reg    <= q[rp].addr;
      wr_data   <= q[rp].data;
    end else begin
      reg_write <= 1'b0;
    end
  end

  // hazard: read address matches a queued or issuing write
  always_comb begin
    hz1 = 1'b0;
    hz2 = 1'b0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = PW'((int'(rp) + i) % DEPTH);
      if (CW'(i) < count) begin
        if (q[idx].addr == bus.rd_addr1) hz1 = 1'b1;
        if (q[idx].addr == bus.rd_addr2) hz2 = 1'b1;
      end
    end
    if (reg_write && wr_reg == bus.rd_addr1) hz1 = 1'b1;
    if (reg_write && wr_reg == bus.rd_addr2) hz2 = 1'b1;
  end

  assign bus.req_ready     = ready;
  assign bus.RegWrite      = reg_write;
  assign bus.WriteRegister = wr_reg;
  assign bus.WriteData     = wr_data;
  assign bus.hazard1 = rst && hz1 &&
                       (bus.rd_addr1 != AW'(REG_ZERO));
  assign bus.hazard2 = rst && hz2 &&
                       (bus.rd_addr2 != AW'(REG_ZERO));

endmodule
